c1541_track_ctrl: RTL and testbench
===================================

Name: c1541_track_ctrl

Overview:
- Sequences SD-card block transfers into and out of the 8 KB GCR track buffer for the 1541 drive.
- On a settled track change it writes back the old track if dirty, then loads the new track's 256-byte sectors from the D64 image.
- Drives `busy` to the GCR engine while the buffer is inconsistent.
- Sits between the head stepper logic and the SD block interface (`sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`).

Parameters:
- SETTLE_CYCLES, 16'd20000: clocks the track must stay stable before a transfer starts.
- MAX_TRACK, 6'd40: highest legal track; larger values clamp to this.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- img_mounted  in  1  one-clock pulse: new image inserted
- img_valid  in  1  image present (img_size != 0)
- img_readonly  in  1  write-protect; suppresses dirty marking
- track  in  6  current head track, 1-based
- mtr  in  1  spindle motor on
- gcr_we  in  1  track-buffer write strobe from GCR engine
- sd_ack  in  1  SD host owns the buffer port; high for the duration of one block
- sd_lba  out  32  256-byte block number
- sd_rd  out  1  block read request
- sd_wr  out  1  block write request
- busy  out  1  buffer not valid for GCR access
- cur_track  out  6  track currently held in the buffer (0 = none)

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, busy=1, cur_track=0, dirty=0, state IDLE.
- Sectors per track (trk clamped to 1..MAX_TRACK, track 0 treated as 1): 1-17 → 21, 18-24 → 19, 25-30 → 18, 31+ → 17.
- Track base LBA:
  - t ≤ 17: (t-1)*21
  - t ≤ 24: 357+(t-18)*19
  - t ≤ 30: 490+(t-25)*18
  - else: 598+(t-31)*17
- Base is computed by a registered 1-cycle function; sd_lba = base + sector, 32-bit zero-extended.
- States:
  - IDLE: busy=0 iff cur_track==clamp(track) and img_valid. If track differs, or a pending mount exists and img_valid → SETTLE with counter cleared. If mtr falls and dirty → FLUSH_REQ with flag no_reload=1.
  - SETTLE: counter increments while track is unchanged; any track change clears it. At SETTLE_CYCLES-1: dirty → FLUSH_REQ (sector 0, old track), else → LOAD_REQ (sector 0, new track). busy=1 from entry.
  - FLUSH_REQ: sd_wr=1 until sd_ack rises → FLUSH_WAIT.
  - FLUSH_WAIT: on sd_ack fall, increment sector. If sector == spt(old)-1 was the last: clear dirty; no_reload → IDLE, else → LOAD_REQ sector 0. Otherwise → FLUSH_REQ.
  - LOAD_REQ / LOAD_WAIT: same handshake using sd_rd. After the last sector: cur_track=new track → IDLE.
- Request is held until sd_ack rises and drops in the same clock as that rise; the next request never issues before sd_ack has fallen.
- dirty is set by gcr_we only when busy=0 and img_readonly=0. gcr_we while busy=1 is ignored.
- img_mounted pulse:
  - Sets mount_pending and clears dirty (the old image is never written back).
  - If a block is mid-transfer (sd_ack=1 or request outstanding), finish that handshake first, then go to SETTLE.
  - cur_track=0 immediately.
- img_valid=0: abort to IDLE after any outstanding handshake completes; busy=1, cur_track=0.
- A track change during FLUSH or LOAD is not serviced mid-sequence. The sequence completes, then IDLE sees the mismatch and re-enters SETTLE.
- Simultaneous track change and mtr fall in IDLE: track change wins; the flush then happens inside the SETTLE path.
- Reset mid-transfer: sd_rd and sd_wr drop immediately; cur_track=0 forces a reload.

Decomposition:
- Package c1541_pkg holds:
  - typedef state enum: IDLE, SETTLE, FLUSH_REQ, FLUSH_WAIT, LOAD_REQ, LOAD_WAIT
  - constants for zone boundaries (18, 25, 31) and zone base LBAs (357, 490, 598)
  - function spt(track)
- One sub-module, c1541_track_lba: registered track → base-LBA/spt calculator. It is shared later by the G64 path.

Test Plan:
- Mount, then track=18, settle → 19 sd_rd blocks with LBAs 357..375; busy falls one clock after the last sd_ack fall; cur_track=18.
- Inject 3 gcr_we on track 18, step to 19 → 19 sd_wr (357..375), then 19 sd_rd (376..394); dirty clears.
- Step 18→19→18 within SETTLE_CYCLES → no SD request; busy returns to 0 with cur_track=18.
- img_readonly=1 with gcr_we pulses, then step → no sd_wr, only reads.
- img_mounted pulse during LOAD_WAIT at sector 5 → current sd_ack completes, no further request for that track, reload restarts at sector 0; no sd_wr issued.
- Track 35 → LBAs 666..682 (17 blocks); track 45 clamps to 40 → LBAs 751..767.

Source files
------------

// File: rtl/c1541_pkg.sv
// Shared types, zone constants and helpers for the 1541 track buffer controller.
package c1541_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FLUSH_REQ,
    FLUSH_WAIT,
    LOAD_REQ,
    LOAD_WAIT
  } state_e;

  // First track of each speed zone and the D64 block where that zone starts.
  localparam logic [5:0]  ZONE2_FIRST = 6'd18;
  localparam logic [5:0]  ZONE3_FIRST = 6'd25;
  localparam logic [5:0]  ZONE4_FIRST = 6'd31;
  localparam logic [15:0] ZONE2_BASE  = 16'd357;
  localparam logic [15:0] ZONE3_BASE  = 16'd490;
  localparam logic [15:0] ZONE4_BASE  = 16'd598;

  // Track 0 is treated as track 1; anything past max_t sits on max_t.
  function automatic logic [5:0] clamp_track(input logic [5:0] t, input logic [5:0] max_t);
    if (t == 6'd0)       return 6'd1;
    else if (t > max_t)  return max_t;
    else                 return t;
  endfunction

  // Sectors per track for an already clamped track number.
  function automatic logic [4:0] spt(input logic [5:0] t);
    if (t < ZONE2_FIRST)      return 5'd21;
    else if (t < ZONE3_FIRST) return 5'd19;
    else if (t < ZONE4_FIRST) return 5'd18;
    else                      return 5'd17;
  endfunction

endpackage

// File: rtl/c1541_track_lba.sv
// Registered track -> first D64 block / sectors-per-track lookup (one clock latency).
module c1541_track_lba
  import c1541_pkg::*;
#(
  parameter logic [5:0] MAX_TRACK = 6'd40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  track,
  output logic [15:0] base_lba,
  output logic [4:0]  sectors
);

  logic [5:0]  trk_c;
  logic [15:0] base_lba_d, base_lba_q;
  logic [4:0]  sectors_d, sectors_q;

  // Zone-relative offset times the zone's sectors-per-track.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    base_lba_d = '0;
    trk_c      = clamp_track(track, MAX_TRACK);
    sectors_d  = spt(trk_c);
    if (trk_c < ZONE2_FIRST)
      base_lba_d = ({10'd0, trk_c} - 16'd1) * 16'd21;
    else if (trk_c < ZONE3_FIRST)
      base_lba_d = ZONE2_BASE + ({10'd0, trk_c} - {10'd0, ZONE2_FIRST}) * 16'd19;
    else if (trk_c < ZONE4_FIRST)
      base_lba_d = ZONE3_BASE + ({10'd0, trk_c} - {10'd0, ZONE3_FIRST}) * 16'd18;
    else
      base_lba_d = ZONE4_BASE + ({10'd0, trk_c} - {10'd0, ZONE4_FIRST}) * 16'd17;
  end

  // Result register; resets to the track-1 values.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      base_lba_q <= '0;
      sectors_q  <= 5'd21;
    end else begin
      base_lba_q <= base_lba_d;
      sectors_q  <= sectors_d;
    end
  end

  assign base_lba = base_lba_q;
  assign sectors  = sectors_q;

endmodule

// File: rtl/c1541_track_ctrl.sv
// Moves whole tracks between the D64 image on SD and the GCR track buffer.
module c1541_track_ctrl
  import c1541_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd20000,
  parameter logic [5:0]  MAX_TRACK     = 6'd40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic        img_valid,
  input  logic        img_readonly,
  input  logic [5:0]  track,
  input  logic        mtr,
  input  logic        gcr_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        busy,
  output logic [5:0]  cur_track
);

  state_e      state_d, state_q;
  logic [15:0] cnt_d, cnt_q;
  logic [4:0]  sector_d, sector_q;
  logic [5:0]  cur_track_d, cur_track_q;
  logic [5:0]  tgt_track_d, tgt_track_q;
  logic [5:0]  flush_track_d, flush_track_q;
  logic [5:0]  trk_prev_d, trk_prev_q;
  logic        dirty_d, dirty_q;
  logic        no_reload_d, no_reload_q;
  logic        mount_pending_d, mount_pending_q;
  logic        mtr_d, mtr_q;

  logic [5:0]  trk_clamped;
  logic [5:0]  lba_trk;
  logic [15:0] base_lba;
  logic [4:0]  sectors;
  logic        abort;
  logic        flushing_next;

  assign trk_clamped = clamp_track(track, MAX_TRACK);
  // A new image or a vanished image ends the sequence once the current block is done.
  assign abort       = mount_pending_q | img_mounted | ~img_valid;
  assign busy        = ~((state_q == IDLE) && img_valid && (cur_track_q == trk_clamped));

  // Feed the lookup with the track the next state will transfer, so the base is ready on entry.
  assign flushing_next = (state_d == FLUSH_REQ) || (state_d == FLUSH_WAIT);
  assign lba_trk       = flushing_next ? flush_track_d : tgt_track_d;

  c1541_track_lba #(.MAX_TRACK(MAX_TRACK)) u_lba (
    .clk      (clk),
    .reset_n  (reset_n),
    .track    (lba_trk),
    .base_lba (base_lba),
    .sectors  (sectors)
  );

  // Next-state logic for the settle / flush / load sequencer plus dirty and mount tracking.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sector_d        = sector_q;
    cur_track_d     = cur_track_q;
    tgt_track_d     = tgt_track_q;
    flush_track_d   = flush_track_q;
    dirty_d         = dirty_q;
    no_reload_d     = no_reload_q;
    mount_pending_d = mount_pending_q;
    trk_prev_d      = track;
    mtr_d           = mtr;

    case (state_q)
      IDLE: begin
        if (img_valid) begin
          // Track change takes priority over a motor-off flush.
          if ((trk_clamped != cur_track_q) || mount_pending_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (mtr_q && !mtr && dirty_q) begin
            state_d     = FLUSH_REQ;
            no_reload_d = 1'b1;
            sector_d    = '0;
          end
        end
      end
      SETTLE: begin
        tgt_track_d = trk_clamped;
        if (!img_valid) begin
          state_d = IDLE;
        end else if ((track != trk_prev_q) || img_mounted) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_CYCLES - 16'd1) begin
          sector_d = '0;
          if (trk_clamped == cur_track_q) begin
            state_d = IDLE;
          end else if (dirty_q) begin
            state_d     = FLUSH_REQ;
            no_reload_d = 1'b0;
          end else begin
            state_d = LOAD_REQ;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      FLUSH_REQ: if (sd_ack) state_d = FLUSH_WAIT;
      FLUSH_WAIT: begin
        if (!sd_ack) begin
          if (abort) begin
            state_d = img_valid ? SETTLE : IDLE;
            cnt_d   = '0;
          end else if (sector_q == sectors - 5'd1) begin
            dirty_d  = 1'b0;
            sector_d = '0;
            state_d  = no_reload_q ? IDLE : LOAD_REQ;
          end else begin
            sector_d = sector_q + 5'd1;
            state_d  = FLUSH_REQ;
          end
        end
      end
      LOAD_REQ: if (sd_ack) state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        if (!sd_ack) begin
          if (abort) begin
            state_d = img_valid ? SETTLE : IDLE;
            cnt_d   = '0;
          end else if (sector_q == sectors - 5'd1) begin
            cur_track_d = tgt_track_q;
            sector_d    = '0;
            state_d     = IDLE;
          end else begin
            sector_d = sector_q + 5'd1;
            state_d  = LOAD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Latch the track being written back, so a mount mid-flush cannot move the LBA.
    if (state_q != FLUSH_REQ && state_q != FLUSH_WAIT && state_d == FLUSH_REQ)
      flush_track_d = cur_track_q;

    if (gcr_we && !busy && !img_readonly)
      dirty_d = 1'b1;

    // The old image is never written back and the buffer no longer holds a valid track.
    if (img_mounted || !img_valid) begin
      dirty_d     = 1'b0;
      cur_track_d = '0;
    end

    if (img_mounted)
      mount_pending_d = 1'b1;
    else if (state_d == SETTLE)
      mount_pending_d = 1'b0;
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sector_q        <= '0;
      cur_track_q     <= '0;
      tgt_track_q     <= '0;
      flush_track_q   <= '0;
      trk_prev_q      <= '0;
      dirty_q         <= 1'b0;
      no_reload_q     <= 1'b0;
      mount_pending_q <= 1'b0;
      mtr_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sector_q        <= sector_d;
      cur_track_q     <= cur_track_d;
      tgt_track_q     <= tgt_track_d;
      flush_track_q   <= flush_track_d;
      trk_prev_q      <= trk_prev_d;
      dirty_q         <= dirty_d;
      no_reload_q     <= no_reload_d;
      mount_pending_q <= mount_pending_d;
      mtr_q           <= mtr_d;
    end
  end

  assign sd_rd     = (state_q == LOAD_REQ);
  assign sd_wr     = (state_q == FLUSH_REQ);
  assign sd_lba    = {16'd0, base_lba + {11'd0, sector_q}};
  assign cur_track = cur_track_q;

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Directed bench for c1541_track_ctrl with a simple SD host responder.
module tb_c1541_track_ctrl;

  localparam logic [15:0] S = 16'd8;
  localparam logic [1:0]  K_RD = 2'b01;
  localparam logic [1:0]  K_WR = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_valid = 1'b0;
  logic        img_readonly = 1'b0;
  logic [5:0]  track = 6'd0;
  logic        mtr = 1'b0;
  logic        gcr_we = 1'b0;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        busy;
  logic [5:0]  cur_track;

  int checks = 0;
  int errors = 0;

  c1541_track_ctrl #(.SETTLE_CYCLES(S), .MAX_TRACK(6'd40)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .img_mounted  (img_mounted),
    .img_valid    (img_valid),
    .img_readonly (img_readonly),
    .track        (track),
    .mtr          (mtr),
    .gcr_we       (gcr_we),
    .sd_ack       (sd_ack),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .busy         (busy),
    .cur_track    (cur_track)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Wait (bounded) for a request, record it, then run one ack pulse; optionally mount mid-block.
  task automatic serve_block(input bit mount_mid, output logic [1:0] kind,
                             output logic [31:0] lba, output bit dropped, output int waited);
    kind = 2'b00; lba = '0; dropped = 1'b0; waited = 0;
    while (kind == 2'b00 && waited < 200) begin
      @(negedge clk); waited++;
      if (sd_rd || sd_wr) begin kind = {sd_wr, sd_rd}; lba = sd_lba; end
    end
    if (kind != 2'b00) begin
      sd_ack = 1'b1;
      @(negedge clk);
      dropped = !sd_rd && !sd_wr;
      if (mount_mid) begin img_mounted = 1'b1; @(negedge clk); img_mounted = 1'b0; end
      repeat (2) @(negedge clk);
      sd_ack = 1'b0;
    end
  endtask

  task automatic pulse_we(input int n);
    for (int i = 0; i < n; i++) begin
      gcr_we = 1'b1; @(negedge clk); gcr_we = 1'b0; @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (sd_lba !== 32'd0 || sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b1 || cur_track !== 6'd0) begin
      errors++;
      $display("FAIL reset: lba=%0d rd=%b wr=%b busy=%b cur=%0d, want 0 0 0 1 0", sd_lba, sd_rd, sd_wr, busy, cur_track);
    end
    reset_n = 1'b1;
    mtr = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || busy !== 1'b1 || cur_track !== 6'd0) begin
      errors++;
      $display("FAIL no_image_idle: rd=%b busy=%b cur=%0d, want 0 1 0", sd_rd, busy, cur_track);
    end
  endtask

  task automatic test_load_18();
    logic [1:0] k; logic [31:0] l; bit d; int w;
    img_valid = 1'b1; img_mounted = 1'b1; track = 6'd18;
    @(negedge clk); img_mounted = 1'b0;
    repeat (S - 1) @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL settle_early: rd=%b busy=%b, want 0 1", sd_rd, busy);
    end
    for (int i = 0; i < 19; i++) begin
      serve_block(1'b0, k, l, d, w);
      checks++;
      if (k !== K_RD || l !== 32'd357 + 32'(i) || !d || (i == 0 && w != 1)) begin
        errors++;
        $display("FAIL load18 blk %0d: kind=%b lba=%0d drop=%b wait=%0d, want rd lba=%0d", i, k, l, d, w, 357 + i);
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_last_fall: busy=%b want 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cur_track !== 6'd18) begin
      errors++; $display("FAIL load18_done: busy=%b cur=%0d, want 0 18", busy, cur_track);
    end
  endtask

  task automatic test_dirty_step();
    logic [1:0] k; logic [31:0] l; bit d; int w;
    pulse_we(3);
    track = 6'd19;
    for (int i = 0; i < 38; i++) begin
      serve_block(1'b0, k, l, d, w);
      checks++;
      if (i < 19 ? (k !== K_WR || l !== 32'd357 + 32'(i)) : (k !== K_RD || l !== 32'd376 + 32'(i - 19))) begin
        errors++;
        $display("FAIL step19 blk %0d: kind=%b lba=%0d, want %s lba=%0d", i, k, l,
                 i < 19 ? "wr" : "rd", i < 19 ? 357 + i : 376 + i - 19);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cur_track !== 6'd19) begin
      errors++; $display("FAIL step19_done: busy=%b cur=%0d, want 0 19", busy, cur_track);
    end
  endtask

  task automatic test_glitch_step();
    int reqs = 0;
    track = 6'd18;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: busy=%b want 1", busy); end
    repeat (2) @(negedge clk);
    track = 6'd19;
    for (int c = 0; c < S + 12; c++) begin @(negedge clk); if (sd_rd || sd_wr) reqs++; end
    checks++;
    if (reqs != 0 || busy !== 1'b0 || cur_track !== 6'd19) begin
      errors++; $display("FAIL glitch_step: reqs=%0d busy=%b cur=%0d, want 0 0 19", reqs, busy, cur_track);
    end
  endtask

  task automatic test_readonly_35();
    logic [1:0] k; logic [31:0] l; bit d; int w;
    img_readonly = 1'b1;
    pulse_we(3);
    track = 6'd35;
    for (int i = 0; i < 17; i++) begin
      serve_block(1'b0, k, l, d, w);
      checks++;
      if (k !== K_RD || l !== 32'd666 + 32'(i)) begin
        errors++; $display("FAIL ro_track35 blk %0d: kind=%b lba=%0d, want rd lba=%0d", i, k, l, 666 + i);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cur_track !== 6'd35) begin
      errors++; $display("FAIL track35_done: busy=%b cur=%0d, want 0 35", busy, cur_track);
    end
    img_readonly = 1'b0;
  endtask

  task automatic test_clamp_45();
    logic [1:0] k; logic [31:0] l; bit d; int w;
    track = 6'd45;
    for (int i = 0; i < 17; i++) begin
      serve_block(1'b0, k, l, d, w);
      checks++;
      if (k !== K_RD || l !== 32'd751 + 32'(i)) begin
        errors++; $display("FAIL clamp45 blk %0d: kind=%b lba=%0d, want rd lba=%0d", i, k, l, 751 + i);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cur_track !== 6'd40) begin
      errors++; $display("FAIL clamp45_done: busy=%b cur=%0d, want 0 40", busy, cur_track);
    end
  endtask

  task automatic test_mount_mid_load();
    logic [1:0] k; logic [31:0] l; bit d; int w;
    track = 6'd18;
    for (int i = 0; i < 6; i++) begin
      serve_block(i == 5, k, l, d, w);
      checks++;
      if (k !== K_RD || l !== 32'd357 + 32'(i)) begin
        errors++; $display("FAIL mid_load blk %0d: kind=%b lba=%0d, want rd lba=%0d", i, k, l, 357 + i);
      end
    end
    checks++;
    if (cur_track !== 6'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL mount_clears_cur: cur=%0d busy=%b, want 0 1", cur_track, busy);
    end
    for (int i = 0; i < 19; i++) begin
      serve_block(1'b0, k, l, d, w);
      checks++;
      if (k !== K_RD || l !== 32'd357 + 32'(i)) begin
        errors++; $display("FAIL reload blk %0d: kind=%b lba=%0d, want rd lba=%0d", i, k, l, 357 + i);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cur_track !== 6'd18) begin
      errors++; $display("FAIL reload_done: busy=%b cur=%0d, want 0 18", busy, cur_track);
    end
  endtask

  task automatic test_mount_dirty();
    logic [1:0] k; logic [31:0] l; bit d; int w;
    pulse_we(2);
    img_mounted = 1'b1; @(negedge clk); img_mounted = 1'b0;
    checks++;
    if (cur_track !== 6'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL mount_idle: cur=%0d busy=%b, want 0 1", cur_track, busy);
    end
    for (int i = 0; i < 19; i++) begin
      serve_block(1'b0, k, l, d, w);
      checks++;
      if (k !== K_RD || l !== 32'd357 + 32'(i)) begin
        errors++; $display("FAIL mount_dirty blk %0d: kind=%b lba=%0d, want rd lba=%0d", i, k, l, 357 + i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_motor_flush();
    logic [1:0] k; logic [31:0] l; bit d; int w;
    int reqs = 0;
    pulse_we(1);
    mtr = 1'b0;
    for (int i = 0; i < 19; i++) begin
      serve_block(1'b0, k, l, d, w);
      checks++;
      if (k !== K_WR || l !== 32'd357 + 32'(i)) begin
        errors++; $display("FAIL motor_flush blk %0d: kind=%b lba=%0d, want wr lba=%0d", i, k, l, 357 + i);
      end
    end
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (sd_rd || sd_wr) reqs++; end
    checks++;
    if (reqs != 0 || busy !== 1'b0 || cur_track !== 6'd18) begin
      errors++; $display("FAIL motor_no_reload: reqs=%0d busy=%b cur=%0d, want 0 0 18", reqs, busy, cur_track);
    end
    mtr = 1'b1;
  endtask

  task automatic test_invalid();
    img_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cur_track !== 6'd0 || sd_rd !== 1'b0) begin
      errors++; $display("FAIL img_invalid: busy=%b cur=%0d rd=%b, want 1 0 0", busy, cur_track, sd_rd);
    end
  endtask

  initial begin
    test_reset();
    test_load_18();
    test_dirty_step();
    test_glitch_step();
    test_readonly_35();
    test_clamp_45();
    test_mount_mid_load();
    test_mount_dirty();
    test_motor_flush();
    test_invalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
